// File: rtl/sspim_pkg.sv
// Shared constants for the SPI master slice: op codes, endianness and arbiter states.
package sspim_pkg;

  localparam logic [1:0] SPI_WR    = 2'b00;
  localparam logic [1:0] SPI_RD    = 2'b01;
  localparam logic [1:0] SPI_WR_RD = 2'b10;

  localparam logic LITTLE_ENDIAN = 1'b0;
  localparam logic BIG_ENDIAN    = 1'b1;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_ACTIVE  = 2'd1;
  localparam logic [1:0] ARB_RELEASE = 2'd2;

endpackage

// File: rtl/sspim_rr_pick.sv
// Combinational round-robin picker with optional grant lock for the last owner.
module sspim_rr_pick #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_rr_ptr,
  input  logic            i_lock_own,
  input  logic [IDW-1:0]  i_last_id,
  output logic [IDW-1:0]  o_winner,
  output logic            o_valid
);

  int unsigned    w_sum;
  logic [IDW-1:0] w_idx;

  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_sum    = 0;
    w_idx    = '0;
    if (i_lock_own && i_req[i_last_id]) begin
      o_winner = i_last_id;
      o_valid  = 1'b1;
    end else begin
      // Scan from the pointer upwards, wrapping; first set request wins.
      for (int unsigned i = 0; i < NREQ; i++) begin
        w_sum = 32'(i_rr_ptr) + i;
        w_idx = IDW'(w_sum % NREQ);
        if (!o_valid && i_req[w_idx]) begin
          o_winner = w_idx;
          o_valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sspim_arb.sv
// Arbiter sharing one sspim_ctl engine between NREQ requesters via the op_req/op_done handshake.
module sspim_arb
  import sspim_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_lock,
  input  logic [2*NREQ-1:0]    req_op_type,
  input  logic [2*NREQ-1:0]    req_tsize,
  input  logic [NREQ-1:0]      req_endian,
  input  logic [8*NREQ-1:0]    req_cs_byte,
  input  logic [32*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          rdata,
  output logic                 busy,
  output logic [IDW-1:0]       gnt_id,
  output logic                 cfg_op_req,
  output logic [1:0]           cfg_op_type,
  output logic [1:0]           cfg_transfer_size,
  output logic                 cfg_endian,
  output logic [7:0]           cfg_cs_byte,
  output logic [31:0]          cfg_datain,
  input  logic [31:0]          cfg_dataout,
  input  logic                 op_done
);

  logic [1:0]      r_state;
  logic [NREQ-1:0] r_ack;
  logic [31:0]     r_rdata;
  logic [IDW-1:0]  r_gnt_id;
  logic [IDW-1:0]  r_rr_ptr;
  logic            r_lock_own;
  logic            r_op_req;
  logic [1:0]      r_op_type;
  logic [1:0]      r_tsize;
  logic            r_endian;
  logic [7:0]      r_cs_byte;
  logic [31:0]     r_datain;

  logic [IDW-1:0]  w_winner;
  logic            w_valid;
  logic [IDW-1:0]  w_next_ptr;
  logic [1:0]      w_sel_op_type;
  logic [1:0]      w_sel_tsize;
  logic            w_sel_endian;
  logic [7:0]      w_sel_cs_byte;
  logic [31:0]     w_sel_wdata;

  sspim_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .i_req      (req),
    .i_rr_ptr   (r_rr_ptr),
    .i_lock_own (r_lock_own),
    .i_last_id  (r_gnt_id),
    .o_winner   (w_winner),
    .o_valid    (w_valid)
  );

  always_comb begin
    w_sel_op_type = '0;
    w_sel_tsize   = '0;
    w_sel_endian  = 1'b0;
    w_sel_cs_byte = '0;
    w_sel_wdata   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_winner == IDW'(i)) begin
        w_sel_op_type = req_op_type[2*i +: 2];
        w_sel_tsize   = req_tsize[2*i +: 2];
        w_sel_endian  = req_endian[i];
        w_sel_cs_byte = req_cs_byte[8*i +: 8];
        w_sel_wdata   = req_wdata[32*i +: 32];
      end
    end
  end

  assign w_next_ptr = (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ARB_IDLE;
      r_ack      <= '0;
      r_rdata    <= '0;
      r_gnt_id   <= '0;
      r_rr_ptr   <= '0;
      r_lock_own <= 1'b0;
      r_op_req   <= 1'b0;
      r_op_type  <= '0;
      r_tsize    <= '0;
      r_endian   <= 1'b0;
      r_cs_byte  <= '0;
      r_datain   <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        ARB_IDLE: begin
          // ctl must be back in IDLE (op_done low) before a new grant.
          if (w_valid && !op_done) begin
            r_gnt_id   <= w_winner;
            r_rr_ptr   <= w_next_ptr;
            r_lock_own <= 1'b0;
            r_op_req   <= 1'b1;
            r_op_type  <= w_sel_op_type;
            r_tsize    <= w_sel_tsize;
            r_endian   <= w_sel_endian;
            r_cs_byte  <= w_sel_cs_byte;
            r_datain   <= w_sel_wdata;
            r_state    <= ARB_ACTIVE;
          end
        end
        ARB_ACTIVE: begin
          if (op_done) begin
            r_rdata    <= cfg_dataout;
            r_ack      <= NREQ'(1) << r_gnt_id;
            r_op_req   <= 1'b0;
            r_lock_own <= req_lock[r_gnt_id];
            r_state    <= ARB_RELEASE;
          end
        end
        ARB_RELEASE: begin
          if (!op_done) begin
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign ack               = r_ack;
  assign rdata             = r_rdata;
  assign busy              = (r_state != ARB_IDLE);
  assign gnt_id            = r_gnt_id;
  assign cfg_op_req        = r_op_req;
  assign cfg_op_type       = r_op_type;
  assign cfg_transfer_size = r_tsize;
  assign cfg_endian        = r_endian;
  assign cfg_cs_byte       = r_cs_byte;
  assign cfg_datain        = r_datain;

endmodule
